// File: rtl/cnt_decoder.sv
// Receive-side decoder for a 4-bit up/down counter stream with step control.
// Optional CNT_DECODER_HOLD_EN makes a zero delta legal and adds a hold output.
module cnt_decoder #(
    parameter int LOCK_LEN = 3,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [3:0]       in,
    input  logic             valid,
    output logic             step,
    output logic             down,
    output logic             cmd_valid,
    output logic             locked,
    output logic             err,
`ifdef CNT_DECODER_HOLD_EN
    output logic             hold,
`endif
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_e;

    state_e            state_q, state_d;
    logic [3:0]        prev_q, prev_d;
    logic [3:0]        run_q, run_d;
    logic              step_q, step_d;
    logic              down_q, down_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              err_q, err_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
`ifdef CNT_DECODER_HOLD_EN
    logic              hold_q, hold_d;
`endif

    logic [3:0] delta;
    logic [4:0] run_nxt;
    logic       legal, dec_step, dec_down;

    always_comb begin
        delta    = in - prev_q;
        run_nxt  = {1'b0, run_q} + 5'd1;
        legal    = 1'b0;
        dec_step = 1'b0;
        dec_down = 1'b0;
        case (delta)
            4'd1:  legal = 1'b1;
            4'd2:  begin legal = 1'b1; dec_step = 1'b1; end
            4'd15: begin legal = 1'b1; dec_down = 1'b1; end
            4'd14: begin legal = 1'b1; dec_step = 1'b1; dec_down = 1'b1; end
`ifdef CNT_DECODER_HOLD_EN
            4'd0:  legal = 1'b1;
`endif
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        run_d       = run_q;
        step_d      = step_q;
        down_d      = down_q;
        cmd_valid_d = 1'b0;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt_q;
`ifdef CNT_DECODER_HOLD_EN
        hold_d      = hold_q;
`endif
        if (valid) begin
            // every sample becomes the new reference, legal or not
            prev_d = in;
            case (state_q)
                IDLE: begin
                    state_d = SYNC;
                    run_d   = 4'd0;
                end
                SYNC: begin
                    if (legal) begin
                        run_d = run_nxt[3:0];
                        if (run_nxt == 5'(LOCK_LEN)) state_d = LOCKED;
                    end else begin
                        run_d = 4'd0;
                    end
                end
                LOCKED: begin
                    if (legal) begin
                        cmd_valid_d = 1'b1;
                        step_d      = dec_step;
                        down_d      = dec_down;
`ifdef CNT_DECODER_HOLD_EN
                        hold_d      = (delta == 4'd0);
`endif
                    end else begin
                        err_d   = 1'b1;
                        run_d   = 4'd0;
                        state_d = SYNC;
                        if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            prev_q      <= 4'd0;
            run_q       <= 4'd0;
            step_q      <= 1'b0;
            down_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
`ifdef CNT_DECODER_HOLD_EN
            hold_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            run_q       <= run_d;
            step_q      <= step_d;
            down_q      <= down_d;
            cmd_valid_q <= cmd_valid_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
`ifdef CNT_DECODER_HOLD_EN
            hold_q      <= hold_d;
`endif
        end
    end

    assign step      = step_q;
    assign down      = down_q;
    assign cmd_valid = cmd_valid_q;
    assign locked    = (state_q == LOCKED);
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;
`ifdef CNT_DECODER_HOLD_EN
    assign hold      = hold_q;
`endif

endmodule

// File: tb/tb_cnt_decoder.sv
// Bench for cnt_decoder: two instances (ERR_W=8 and ERR_W=2) share one stimulus
// stream and are checked every cycle against an arithmetic model of the stream rules.
module tb_cnt_decoder;

    localparam int LL = 3;

    logic       clk = 1'b0;
    logic       nrst = 1'b1;
    logic       valid = 1'b0;
    logic [3:0] in = 4'd0;

    logic       a_step, a_down, a_cv, a_locked, a_err;
    logic [7:0] a_err_cnt;
    logic       b_step, b_down, b_cv, b_locked, b_err;
    logic [1:0] b_err_cnt;
`ifdef CNT_DECODER_HOLD_EN
    logic       a_hold, b_hold;
`endif

    cnt_decoder #(.LOCK_LEN(LL), .ERR_W(8)) u_a (
        .clk(clk), .nrst(nrst), .in(in), .valid(valid),
        .step(a_step), .down(a_down), .cmd_valid(a_cv), .locked(a_locked), .err(a_err),
`ifdef CNT_DECODER_HOLD_EN
        .hold(a_hold),
`endif
        .err_cnt(a_err_cnt));

    cnt_decoder #(.LOCK_LEN(LL), .ERR_W(2)) u_b (
        .clk(clk), .nrst(nrst), .in(in), .valid(valid),
        .step(b_step), .down(b_down), .cmd_valid(b_cv), .locked(b_locked), .err(b_err),
`ifdef CNT_DECODER_HOLD_EN
        .hold(b_hold),
`endif
        .err_cnt(b_err_cnt));

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // model: phase 0 = waiting for first sample, 1 = qualifying, 2 = locked
    int   m_phase, m_prev, m_run, m_errs;
    logic e_step, e_down, e_cv, e_err, e_hold;
    int   cur;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int n, input int w);
        return (n > (1 << w) - 1) ? (1 << w) - 1 : n;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_prev = 0; m_run = 0; m_errs = 0;
        e_step = 0; e_down = 0; e_cv = 0; e_err = 0; e_hold = 0;
    endtask

    task automatic model_sample(input logic v, input int x);
        int  d;
        bit  ok;
        e_cv  = 0;
        e_err = 0;
        if (!v) return;
        d  = (x - m_prev + 16) % 16;
        ok = (d == 1) || (d == 2) || (d == 14) || (d == 15);
`ifdef CNT_DECODER_HOLD_EN
        ok = ok || (d == 0);
`endif
        if (m_phase == 0) begin
            m_phase = 1; m_run = 0;
        end else if (m_phase == 1) begin
            if (ok) begin
                m_run++;
                if (m_run == LL) m_phase = 2;
            end else m_run = 0;
        end else begin
            if (ok) begin
                e_cv   = 1;
                e_step = (d == 2) || (d == 14);
                e_down = (d >= 14);
                e_hold = (d == 0);
            end else begin
                e_err = 1; m_errs++; m_run = 0; m_phase = 1;
            end
        end
        m_prev = x;
    endtask

    always @(negedge clk) begin
        chk("a_step", a_step, e_step);
        chk("a_down", a_down, e_down);
        chk("a_cmd_valid", a_cv, e_cv);
        chk("a_locked", a_locked, (m_phase == 2));
        chk("a_err", a_err, e_err);
        chk("a_err_cnt", a_err_cnt, sat(m_errs, 8));
        chk("b_step", b_step, e_step);
        chk("b_down", b_down, e_down);
        chk("b_cmd_valid", b_cv, e_cv);
        chk("b_locked", b_locked, (m_phase == 2));
        chk("b_err", b_err, e_err);
        chk("b_err_cnt", {30'd0, b_err_cnt}, sat(m_errs, 2));
`ifdef CNT_DECODER_HOLD_EN
        chk("a_hold", a_hold, e_hold);
        chk("b_hold", b_hold, e_hold);
`endif
    end

    task automatic send(input logic v, input int x);
        valid = v;
        in    = 4'(x);
        @(posedge clk);
        model_sample(v, x);
        if (v) cur = x;
        #1;
    endtask

    initial begin
        model_reset();
        cur = 0;
        #2 nrst = 1'b0;
        #20;
        chk("rst_locked", a_locked, 0);
        chk("rst_cv", a_cv, 0);
        chk("rst_err_cnt", a_err_cnt, 0);
        @(posedge clk); #1 nrst = 1'b1;

        // acquire lock
        for (int i = 3; i <= 6; i++) send(1, i);
        chk("lock_after_6", a_locked, 1);
        chk("no_cv_on_lock", a_cv, 0);
        send(1, 7);
        chk("first_cv", a_cv, 1);
        chk("first_step", a_step, 0);
        chk("first_down", a_down, 0);
        chk("first_err_cnt", a_err_cnt, 0);
        send(1, 8);

        // +2/-1/-2 decodes including wrap in both directions
        for (int i = 9; i <= 12; i++) send(1, i);
        send(1, 14); send(1, 0);
        chk("wrap_up_step", a_step, 1);
        chk("wrap_up_down", a_down, 0);
        send(1, 2); send(1, 1);
        send(1, 15);
        chk("wrap_dn_cv", a_cv, 1);
        chk("wrap_dn_step", a_step, 1);
        chk("wrap_dn_down", a_down, 1);
        send(1, 13);

        // illegal jump from locked, then re-lock
        for (int i = 14; i <= 21; i++) send(1, i % 16);
        send(1, 9);
        chk("err_pulse", a_err, 1);
        chk("err_cnt_1", a_err_cnt, 1);
        send(1, 10);
        chk("unlocked", a_locked, 0);
        chk("err_one_cycle", a_err, 0);
        send(1, 11); send(1, 12);
        chk("relocked", a_locked, 1);
        send(1, 13);
        chk("relock_cv", a_cv, 1);

        // gaps with garbage on in are ignored
        send(1, 14); send(1, 15); send(1, 0); send(1, 1); send(1, 2);
        send(0, 7); send(0, 11);
        send(1, 3);
        chk("gap_cv", a_cv, 1);
        chk("gap_step", a_step, 0);
        chk("gap_down", a_down, 0);

        // five more errors, re-locking between them
        for (int k = 0; k < 5; k++) begin
            send(1, (cur + 5) % 16);
            for (int j = 0; j < LL; j++) send(1, (cur + 1) % 16);
        end
        chk("sat_b", {30'd0, b_err_cnt}, 3);
        chk("count_a", a_err_cnt, 6);

        // asynchronous reset while locked
        send(1, (cur + 1) % 16);
        #2 nrst = 1'b0;
        model_reset();
        #1;
        chk("async_locked", a_locked, 0);
        chk("async_err_cnt", a_err_cnt, 0);
        chk("async_step", a_step, 0);
        @(posedge clk); #1 nrst = 1'b1;
        send(1, 7);
        chk("post_rst_idle", a_locked, 0);
        send(1, 8); send(1, 9); send(1, 10);
        chk("post_rst_lock", a_locked, 1);
        send(1, 11);
        chk("post_rst_cv", a_cv, 1);
        send(0, 0);
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
